keypad_emulator: RTL
====================

Name: keypad_emulator

Overview:
- Synthesizable model of a 4x4 active-high matrix keypad; the responder side of the row-scan/column-sense interface.
- Takes key-press commands (key code, hold time, optional second key). Drives col[3:0] from the scanner's row[3:0] drive as a physical keypad would, including contact bounce on press and release.
- Used for on-FPGA self-test and in benches, in place of the real keypad.

Parameters:
TICK_CYCLES, 12000, clk cycles per timing tick (1 ms at 12 MHz)
BOUNCE_TICKS, 4, ticks of pseudo-random bounce on press and on release; 0 disables bounce
GAP_TICKS, 2, ticks of guaranteed release after the release bounce, before done
HOLD_W, 12, width of cmd_hold
LFSR_SEED, 8'hA5, bounce LFSR reset value; must be nonzero

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
row  in  4  row drive from scanner; bit high = row powered; multiple bits may be high
col  out  4  column sense; bit high = closed key connects a powered row to that column
cmd_valid  in  1  command offered
cmd_ready  out  1  emulator idle, can accept a command
cmd_key  in  4  hex key code of primary key
cmd_key2  in  4  hex key code of secondary key
cmd_key2_en  in  1  also press cmd_key2, bounce-free, for the full hold
cmd_hold  in  HOLD_W  stable-closed duration in ticks; 0 treated as 1
busy  out  1  command in progress
contact  out  1  current primary contact state (debug)
done  out  1  one-cycle pulse at command completion

Behaviour:
- Key map, row r / col c:
  - r0 = 1,2,3,A
  - r1 = 4,5,6,B
  - r2 = 7,8,9,C
  - r3 = E,0,F,D
  - Col index is left to right. Example: key 5 = r1c1, key 0 = r3c1, key D = r3c3.
- col is combinational from row and registered state: col[c] = OR over each active key k with col(k)==c of (row[row(k)] && closed(k)).
  - Primary closed = contact.
  - Secondary closed = key2_en_q && state==HOLD.
  - Same key in both slots: result is the logical OR.
- Reset (synchronous, active-high) forces the following on the next edge:
  - state=IDLE, contact=0, busy=0, done=0, lfsr=LFSR_SEED, tick counter=0, latched command cleared.
  - cmd_ready=0 while reset is high; commands offered then are ignored.
  - Reset mid-command: command discarded, col all-zero from the next cycle, no done.
- Handshake:
  - cmd_ready = (state==IDLE) && !reset.
  - Accept on the edge where cmd_valid && cmd_ready; latch key, key2, key2_en, hold (0→1).
  - The prescaler restarts at 0 on accept.
  - cmd_* ignored while busy. busy=1 from the cycle after accept through the done cycle.
- Tick: prescaler counts 0..TICK_CYCLES-1; tick strobe when count==TICK_CYCLES-1. Phase counters decrement only on tick.
- States:
  - IDLE: contact=0. On accept → BOUNCE_P, or → HOLD if BOUNCE_TICKS==0.
  - BOUNCE_P: contact=lfsr[0].
    - On each tick, advance the LFSR (x^8+x^6+x^5+x^4+1, Fibonacci, shift left; new bit = XOR of bits 7,5,4,3).
    - After BOUNCE_TICKS ticks → HOLD.
  - HOLD: contact=1; secondary closed. After cmd_hold ticks → BOUNCE_R, or → GAP if BOUNCE_TICKS==0.
  - BOUNCE_R: contact=lfsr[0], LFSR advances per tick. After BOUNCE_TICKS ticks → GAP.
  - GAP: contact=0. After GAP_TICKS ticks → DONE. GAP_TICKS==0 → DONE immediately on the next edge.
  - DONE: one cycle, done=1, then → IDLE. The next accept is possible the cycle after DONE.
- Contact updates are registered: the value changes on the edge after the tick or state change.
- The LFSR holds its value outside bounce states and is not reseeded per command, so successive commands bounce differently.
- Tick counts:
  - Hold counter is HOLD_W bits, loaded with cmd_hold, no wrap; max hold = 2^HOLD_W-1 ticks.
  - Bounce and gap counters are sized $clog2(max+1).
- Total command length in clocks = TICK_CYCLES*(2*BOUNCE_TICKS+hold+GAP_TICKS) + 1 (DONE), ±1 for the accept edge.

Test Plan:
- Reset 2 cycles with cmd_valid=1 → cmd_ready=0 and col=0 throughout; contact=0; after release cmd_ready=1, lfsr=8'hA5.
- TICK_CYCLES=4, BOUNCE_TICKS=0, GAP_TICKS=1, key 5, hold 3, row sweeping one-hot:
  - col=4'b0010 only while row[1]=1 during HOLD (12 clocks), else 0.
  - done pulses once, 17±1 clocks after accept.
- Same settings, row=4'b1111, key D, key2_en=1, key2=0:
  - HOLD col=4'b1010.
  - row=4'b0111 → col=0.
  - Secondary never closed outside HOLD.
- BOUNCE_TICKS=4, key 1, row=4'b0001:
  - col[0] sequence during BOUNCE_P follows lfsr[0] from seed A5 per tick, then steady 1 for hold, bounce again, then 0 for GAP.
  - Matches the reference LFSR model.
- cmd_hold=0 → behaves as hold 1. A cmd_valid pulse mid-command is ignored (no second done). Back-to-back command accepted the cycle after done.
- Reset asserted during HOLD (key 9, row=4'b0100) → col drops to 0 on the next edge, no done, cmd_ready=1 the cycle after reset deasserts.

Source files
------------

// File: rtl/keypad_emulator.sv
// 4x4 active-high matrix keypad responder: drives col from row per the latched key,
// with LFSR contact bounce around a timed stable-closed hold.
module keypad_emulator #(
  parameter int         TICK_CYCLES  = 12000,
  parameter int         BOUNCE_TICKS = 4,
  parameter int         GAP_TICKS    = 2,
  parameter int         HOLD_W       = 12,
  parameter logic [7:0] LFSR_SEED    = 8'hA5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        row,
  output logic [3:0]        col,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [3:0]        cmd_key,
  input  logic [3:0]        cmd_key2,
  input  logic              cmd_key2_en,
  input  logic [HOLD_W-1:0] cmd_hold,
  output logic              busy,
  output logic              contact,
  output logic              done
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_BOUNCE_P = 3'd1;
  localparam logic [2:0] S_HOLD     = 3'd2;
  localparam logic [2:0] S_BOUNCE_R = 3'd3;
  localparam logic [2:0] S_GAP      = 3'd4;
  localparam logic [2:0] S_DONE     = 3'd5;

  localparam int PW = (TICK_CYCLES  > 1) ? $clog2(TICK_CYCLES)    : 1;
  localparam int BW = (BOUNCE_TICKS > 0) ? $clog2(BOUNCE_TICKS+1) : 1;
  localparam int GW = (GAP_TICKS    > 0) ? $clog2(GAP_TICKS+1)    : 1;

  logic [2:0]        state, state_n;
  logic [PW-1:0]     presc;
  logic [HOLD_W-1:0] hold_cnt;
  logic [BW-1:0]     bnc_cnt;
  logic [GW-1:0]     gap_cnt;
  logic [7:0]        lfsr, lfsr_n, lfsr_adv;
  logic [3:0]        key_q, key2_q;
  logic              key2_en_q;
  logic              tick, accept, bouncing, contact_n;
  logic [3:0]        p_rc, s_rc;

  // {row, col} position of a hex key on the pad
  function automatic logic [3:0] key_rc(input logic [3:0] k);
    case (k)
      4'h1: key_rc = 4'b0000;  4'h2: key_rc = 4'b0001;
      4'h3: key_rc = 4'b0010;  4'hA: key_rc = 4'b0011;
      4'h4: key_rc = 4'b0100;  4'h5: key_rc = 4'b0101;
      4'h6: key_rc = 4'b0110;  4'hB: key_rc = 4'b0111;
      4'h7: key_rc = 4'b1000;  4'h8: key_rc = 4'b1001;
      4'h9: key_rc = 4'b1010;  4'hC: key_rc = 4'b1011;
      4'hE: key_rc = 4'b1100;  4'h0: key_rc = 4'b1101;
      4'hF: key_rc = 4'b1110;  4'hD: key_rc = 4'b1111;
    endcase
  endfunction

  assign cmd_ready = (state == S_IDLE) && !reset;
  assign accept    = cmd_valid && cmd_ready;
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign tick      = (presc == PW'(TICK_CYCLES-1));
  assign bouncing  = (state == S_BOUNCE_P) || (state == S_BOUNCE_R);
  assign lfsr_adv  = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  assign p_rc      = key_rc(key_q);
  assign s_rc      = key_rc(key2_q);

  always_comb begin
    state_n = state;
    lfsr_n  = lfsr;
    case (state)
      S_IDLE:     if (accept) state_n = (BOUNCE_TICKS == 0) ? S_HOLD : S_BOUNCE_P;
      S_BOUNCE_P: if (tick) begin
                    lfsr_n = lfsr_adv;
                    if (bnc_cnt == BW'(1)) state_n = S_HOLD;
                  end
      S_HOLD:     if (tick && hold_cnt == HOLD_W'(1))
                    state_n = (BOUNCE_TICKS == 0) ? S_GAP : S_BOUNCE_R;
      S_BOUNCE_R: if (tick) begin
                    lfsr_n = lfsr_adv;
                    if (bnc_cnt == BW'(1)) state_n = S_GAP;
                  end
      S_GAP:      if (GAP_TICKS == 0 || (tick && gap_cnt == GW'(1))) state_n = S_DONE;
      S_DONE:     state_n = S_IDLE;
      default:    state_n = S_IDLE;
    endcase
  end

  // contact is registered from the next state so it tracks state/lfsr without lag
  always_comb begin
    contact_n = 1'b0;
    case (state_n)
      S_BOUNCE_P, S_BOUNCE_R: contact_n = lfsr_n[0];
      S_HOLD:                 contact_n = 1'b1;
      default:                contact_n = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      contact   <= 1'b0;
      lfsr      <= LFSR_SEED;
      presc     <= '0;
      hold_cnt  <= '0;
      bnc_cnt   <= '0;
      gap_cnt   <= '0;
      key_q     <= '0;
      key2_q    <= '0;
      key2_en_q <= 1'b0;
    end else begin
      state   <= state_n;
      lfsr    <= lfsr_n;
      contact <= contact_n;
      presc   <= (accept || tick) ? '0 : presc + PW'(1);
      if (accept) begin
        key_q     <= cmd_key;
        key2_q    <= cmd_key2;
        key2_en_q <= cmd_key2_en;
        hold_cnt  <= (cmd_hold == '0) ? HOLD_W'(1) : cmd_hold;
      end else if (state == S_HOLD && tick) begin
        hold_cnt <= hold_cnt - HOLD_W'(1);
      end
      // bounce counter rearms while idle or holding, ready for the next bounce phase
      if (bouncing) begin
        if (tick) bnc_cnt <= bnc_cnt - BW'(1);
      end else begin
        bnc_cnt <= BW'(BOUNCE_TICKS);
      end
      if (state == S_GAP) begin
        if (tick) gap_cnt <= gap_cnt - GW'(1);
      end else begin
        gap_cnt <= GW'(GAP_TICKS);
      end
    end
  end

  always_comb begin
    col = 4'b0000;
    if (contact && row[p_rc[3:2]]) col[p_rc[1:0]] = 1'b1;
    if (key2_en_q && state == S_HOLD && row[s_rc[3:2]]) col[s_rc[1:0]] = 1'b1;
  end

endmodule
